decode_stage: RTL and testbench
===============================

# decode_stage

Second pipeline stage, directly downstream of the fetch stage. Captures the 32-bit instruction returned on the instruction memory read channel, aligns it with the fetch stage's registered PC, and decodes it into register addresses, a sign-extended 64-bit immediate and an illegal-instruction flag. Holds its own pipeline registers so the execute stage sees stable, aligned fields. Also drives the register-file read addresses combinationally.

## Interface
- No parameters.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- squash_i  in  1  kill the instruction in this stage.
- bubble_i  in  1  insert an invalid slot downstream.
- stall_i  in  1  freeze all stage state.
- valid_i  in  1  fetch-stage valid.
- pc_i  in  64  fetch-stage PC.
- next_pc_i  in  64  fetch-stage PC+4.
- imem_rdata_i  in  32  instruction memory read data.
- imem_rvalid_i  in  1  read data valid this cycle.
- rs1_addr_ao  out  5  combinational rs1 index of the current instruction, for register-file read.
- rs2_addr_ao  out  5  combinational rs2 index of the current instruction.
- valid_o  out  1  registered valid.
- pc_o, next_pc_o  out  64  registered pass-through.
- opcode_o  out  7  inst[6:0].
- funct3_o  out  3  inst[14:12].
- funct7_o  out  7  inst[31:25].
- rd_addr_o, rs1_addr_o, rs2_addr_o  out  5  register indices.
- imm_o  out  64  sign-extended immediate.
- illegal_o  out  1  unsupported encoding.

## Operation
- Instruction hold: `inst_saved` (32b) and `inst_held` (1b) registers.
  - Set: when imem_rvalid_i=1 and stall_i=1, capture imem_rdata_i into inst_saved and set inst_held.
  - Clear: inst_held clears on any edge with stall_i=0, or on any edge with squash_i=1.
  - Selection: current instruction is inst_saved if inst_held=1, otherwise imem_rdata_i.
- Precondition: valid_i=1 with imem_rvalid_i=0 and inst_held=0 only occurs while stall_i=1. The hazard unit stalls on the imem stall signal. Not checked in RTL.
- Immediate select by opcode; all immediates are sign-extended from inst[31] to 64 bits:
  - I-type (0000011, 0010011, 0011011, 1100111): inst[31:20].
  - S-type (0100011): {inst[31:25], inst[11:7]}.
  - B-type (1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}, sign-extended from bit 31.
  - J-type (1101111): {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type, others: 0.
- illegal is set when either condition holds:
  - inst[1:0] != 11;
  - opcode is not one of the RV64I set: the above plus 0110011, 0111011, 0001111, 1110011.
- Register-file reads: rs1_addr_ao = inst[19:15] and rs2_addr_ao = inst[24:20] of the current instruction, regardless of valid or stall.

## Timing
- Reset (asynchronous, immediate): every output register is 0, inst_saved=0, inst_held=0.
- Latency: fields are decoded combinationally and registered at the edge where stall_i=0. One cycle from fetch-register output to decode output.
- Edge priority for valid_o:
  - squash_i=1: valid_o <= 0, even if stall_i=1. Other outputs follow the stall rule.
  - else if stall_i=1: all outputs hold.
  - else: valid_o <= valid_i & ~bubble_i, and all fields load.
- Fields load even when the resulting valid_o=0. Downstream qualifies everything with valid_o.
- Stall with rvalid on the same edge: the capture happens and outputs hold. On the first unstalled edge the captured word is decoded, and inst_held clears on that same edge.
- rvalid while not stalled: the data is consumed directly and never saved.
- Reset asserted mid-stall: the held word is discarded.

## Test plan
- Reset and basic decode:
  - Stimulus: reset, then valid_i=1, pc_i=0x1000, rdata=0x00500093 with rvalid.
  - Required one edge later: valid_o=1, pc_o=0x1000, next_pc_o=0x1004, rd=1, rs1=0, imm=5, opcode=0x13, illegal=0.
- Immediate sign extension:
  - 0xFFF00113 -> imm=0xFFFFFFFFFFFFFFFF.
  - 0xFE000CE3 (beq) -> imm=0xFFFFFFFFFFFFFFF8.
  - 0x800002B7 (lui) -> imm=0xFFFFFFFF80000000.
  - 0x0000006F -> imm=0.
- Stall capture:
  - Stimulus: stall_i=1, rvalid with 0x00500093 in cycle 0; rdata=0xDEADBEEF with rvalid=0 for 2 cycles; then stall_i=0.
  - Required: outputs hold during the stall, then decode 0x00500093 (rd=1, imm=5); inst_held=0 afterwards.
- Squash beats stall:
  - Stimulus: valid_o=1, then stall_i=1 and squash_i=1 on the same edge.
  - Required: valid_o=0, pc_o unchanged, held word discarded.
- Bubble:
  - Stimulus: valid_i=1, bubble_i=1, stall_i=0.
  - Required: valid_o=0 and pc_o updated.
- Illegal and async reset:
  - 0x00000000 -> illegal_o=1.
  - 0x0000707B -> illegal_o=1.
  - rst_i pulsed mid-cycle -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: aligns the imem read word with the fetch-stage PC,
// decodes RV64I fields and immediates, and registers them for the execute stage.
module decode_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        squash_i,
  input  logic        bubble_i,
  input  logic        stall_i,
  input  logic        valid_i,
  input  logic [63:0] pc_i,
  input  logic [63:0] next_pc_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_rvalid_i,
  output logic [4:0]  rs1_addr_ao,
  output logic [4:0]  rs2_addr_ao,
  output logic        valid_o,
  output logic [63:0] pc_o,
  output logic [63:0] next_pc_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rd_addr_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [63:0] imm_o,
  output logic        illegal_o
);

  logic [31:0] inst_saved;
  logic        inst_held;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [63:0] imm;
  logic        illegal;

  // A word returned while stalled would otherwise be lost once imem moves on.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_saved <= 32'd0;
      inst_held  <= 1'b0;
    end else if (squash_i || !stall_i) begin
      inst_held  <= 1'b0;
    end else if (imem_rvalid_i) begin
      inst_saved <= imem_rdata_i;
      inst_held  <= 1'b1;
    end
  end

  assign inst        = inst_held ? inst_saved : imem_rdata_i;
  assign opcode      = inst[6:0];
  assign rs1_addr_ao = inst[19:15];
  assign rs2_addr_ao = inst[24:20];

  always_comb begin
    imm     = 64'd0;
    illegal = 1'b0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111:
        imm = {{52{inst[31]}}, inst[31:20]};
      7'b0100011:
        imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      7'b1100011:
        imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {{32{inst[31]}}, inst[31:12], 12'd0};
      7'b1101111:
        imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      7'b0110011, 7'b0111011, 7'b0001111, 7'b1110011:
        imm = 64'd0;
      default:
        illegal = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) illegal = 1'b1;
  end

  // Squash kills valid even under stall; fields only move when unstalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      pc_o       <= 64'd0;
      next_pc_o  <= 64'd0;
      opcode_o   <= 7'd0;
      funct3_o   <= 3'd0;
      funct7_o   <= 7'd0;
      rd_addr_o  <= 5'd0;
      rs1_addr_o <= 5'd0;
      rs2_addr_o <= 5'd0;
      imm_o      <= 64'd0;
      illegal_o  <= 1'b0;
    end else begin
      if (squash_i)
        valid_o <= 1'b0;
      else if (!stall_i)
        valid_o <= valid_i & ~bubble_i;
      if (!stall_i) begin
        pc_o       <= pc_i;
        next_pc_o  <= next_pc_i;
        opcode_o   <= opcode;
        funct3_o   <= inst[14:12];
        funct7_o   <= inst[31:25];
        rd_addr_o  <= inst[11:7];
        rs1_addr_o <= inst[19:15];
        rs2_addr_o <= inst[24:20];
        imm_o      <= imm;
        illegal_o  <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        squash_i, bubble_i, stall_i, valid_i;
  logic [63:0] pc_i, next_pc_i;
  logic [31:0] imem_rdata_i;
  logic        imem_rvalid_i;
  logic [4:0]  rs1_addr_ao, rs2_addr_ao;
  logic        valid_o;
  logic [63:0] pc_o, next_pc_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  rd_addr_o, rs1_addr_o, rs2_addr_o;
  logic [63:0] imm_o;
  logic        illegal_o;

  int tests_run = 0;
  int tests_failed = 0;

  decode_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .squash_i(squash_i), .bubble_i(bubble_i),
    .stall_i(stall_i), .valid_i(valid_i), .pc_i(pc_i), .next_pc_i(next_pc_i),
    .imem_rdata_i(imem_rdata_i), .imem_rvalid_i(imem_rvalid_i),
    .rs1_addr_ao(rs1_addr_ao), .rs2_addr_ao(rs2_addr_ao), .valid_o(valid_o),
    .pc_o(pc_o), .next_pc_o(next_pc_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
    .funct7_o(funct7_o), .rd_addr_o(rd_addr_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .imm_o(imm_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] word,
                       input logic rv, input logic st, input logic sq, input logic bb);
    valid_i = v; pc_i = pc; next_pc_i = pc + 64'd4; imem_rdata_i = word;
    imem_rvalid_i = rv; stall_i = st; squash_i = sq; bubble_i = bb;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    rst_i = 1'b0;
    #1;
    tests_run++;
    if ({valid_o, pc_o, next_pc_o, opcode_o, funct3_o, funct7_o, rd_addr_o,
         rs1_addr_o, rs2_addr_o, imm_o, illegal_o} !== '0) begin
      $display("[TB] FAIL reset_state: outputs not all zero (valid=%0b pc=%h imm=%h)",
               valid_o, pc_o, imm_o);
      tests_failed++;
    end
  endtask

  task automatic test_basic_decode();
    drive(1'b1, 64'h1000, 32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (rs2_addr_ao !== 5'd5) begin
      $display("[TB] FAIL basic_rs2_comb: got %0d expected 5", rs2_addr_ao); tests_failed++;
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || pc_o !== 64'h1000 || next_pc_o !== 64'h1004) begin
      $display("[TB] FAIL basic_pc: valid=%0b pc=%h npc=%h expected 1 1000 1004",
               valid_o, pc_o, next_pc_o); tests_failed++;
    end
    tests_run++;
    if (rd_addr_o !== 5'd1 || rs1_addr_o !== 5'd0 || opcode_o !== 7'h13 ||
        funct3_o !== 3'd0 || illegal_o !== 1'b0) begin
      $display("[TB] FAIL basic_fields: rd=%0d rs1=%0d op=%h f3=%0d ill=%0b expected 1 0 13 0 0",
               rd_addr_o, rs1_addr_o, opcode_o, funct3_o, illegal_o); tests_failed++;
    end
    tests_run++;
    if (imm_o !== 64'd5) begin
      $display("[TB] FAIL basic_imm: got %h expected 5", imm_o); tests_failed++;
    end
  endtask

  task automatic test_imm_sign_ext();
    logic [31:0] words [4];
    logic [63:0] imms  [4];
    words[0] = 32'hFFF00113; imms[0] = 64'hFFFFFFFFFFFFFFFF;
    words[1] = 32'hFE000CE3; imms[1] = 64'hFFFFFFFFFFFFFFF8;
    words[2] = 32'h800002B7; imms[2] = 64'hFFFFFFFF80000000;
    words[3] = 32'h0000006F; imms[3] = 64'h0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h2000 + 64'(i * 4), words[i], 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tests_run++;
      if (imm_o !== imms[i] || illegal_o !== 1'b0) begin
        $display("[TB] FAIL imm_%h: imm=%h ill=%0b expected %h 0",
                 words[i], imm_o, illegal_o, imms[i]); tests_failed++;
      end
    end
  endtask

  task automatic test_stall_capture();
    drive(1'b1, 64'h3000, 32'hFFF00113, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h3004, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    imem_rdata_i = 32'hDEADBEEF; imem_rvalid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (rs2_addr_ao !== 5'd5) begin
        $display("[TB] FAIL stall_held_rs2: got %0d expected 5", rs2_addr_ao); tests_failed++;
      end
      tick();
      tests_run++;
      if (pc_o !== 64'h3000 || imm_o !== 64'hFFFFFFFFFFFFFFFF || rd_addr_o !== 5'd2 ||
          valid_o !== 1'b1) begin
        $display("[TB] FAIL stall_hold: pc=%h imm=%h rd=%0d valid=%0b expected 3000 ffffffffffffffff 2 1",
                 pc_o, imm_o, rd_addr_o, valid_o); tests_failed++;
      end
    end
    stall_i = 1'b0;
    tick();
    tests_run++;
    if (pc_o !== 64'h3004 || rd_addr_o !== 5'd1 || imm_o !== 64'd5 || valid_o !== 1'b1) begin
      $display("[TB] FAIL stall_release: pc=%h rd=%0d imm=%h valid=%0b expected 3004 1 5 1",
               pc_o, rd_addr_o, imm_o, valid_o); tests_failed++;
    end
    tests_run++;
    if (rs2_addr_ao !== 5'd10) begin
      $display("[TB] FAIL stall_held_cleared: rs2_ao=%0d expected 10", rs2_addr_ao); tests_failed++;
    end
  endtask

  task automatic test_squash_beats_stall();
    drive(1'b1, 64'h4000, 32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h5000, 32'hFFF00113, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (valid_o !== 1'b0 || pc_o !== 64'h4000 || imm_o !== 64'd5) begin
      $display("[TB] FAIL squash_stall: valid=%0b pc=%h imm=%h expected 0 4000 5",
               valid_o, pc_o, imm_o); tests_failed++;
    end
    drive(1'b1, 64'h5000, 32'h00A00093, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    tests_run++;
    if (rs2_addr_ao !== 5'd10) begin
      $display("[TB] FAIL squash_discard_rs2: got %0d expected 10", rs2_addr_ao); tests_failed++;
    end
    tick();
    tests_run++;
    if (imm_o !== 64'd10 || valid_o !== 1'b1 || pc_o !== 64'h5000) begin
      $display("[TB] FAIL squash_discard: imm=%h valid=%0b pc=%h expected a 1 5000",
               imm_o, valid_o, pc_o); tests_failed++;
    end
  endtask

  task automatic test_bubble();
    drive(1'b1, 64'h6000, 32'h00500093, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    tests_run++;
    if (valid_o !== 1'b0 || pc_o !== 64'h6000 || next_pc_o !== 64'h6004) begin
      $display("[TB] FAIL bubble: valid=%0b pc=%h npc=%h expected 0 6000 6004",
               valid_o, pc_o, next_pc_o); tests_failed++;
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 64'h7000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (illegal_o !== 1'b1) begin
      $display("[TB] FAIL illegal_zero: got %0b expected 1", illegal_o); tests_failed++;
    end
    drive(1'b1, 64'h7004, 32'h0000707B, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (illegal_o !== 1'b1 || opcode_o !== 7'h7B) begin
      $display("[TB] FAIL illegal_opcode: ill=%0b op=%h expected 1 7b", illegal_o, opcode_o);
      tests_failed++;
    end
    drive(1'b1, 64'h7008, 32'h00208033, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (illegal_o !== 1'b0 || imm_o !== 64'd0 || rs2_addr_o !== 5'd2 || rs1_addr_o !== 5'd1) begin
      $display("[TB] FAIL rtype_legal: ill=%0b imm=%h rs1=%0d rs2=%0d expected 0 0 1 2",
               illegal_o, imm_o, rs1_addr_o, rs2_addr_o); tests_failed++;
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'h8000, 32'hFFF00113, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8004, 32'hFFF00113, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    #2;
    rst_i = 1'b1;
    #1;
    tests_run++;
    if ({valid_o, pc_o, next_pc_o, opcode_o, funct3_o, funct7_o, rd_addr_o,
         rs1_addr_o, rs2_addr_o, imm_o, illegal_o} !== '0) begin
      $display("[TB] FAIL async_reset: valid=%0b pc=%h imm=%h expected all zero",
               valid_o, pc_o, imm_o); tests_failed++;
    end
    #1;
    rst_i = 1'b0;
    imem_rdata_i = 32'h00500093; imem_rvalid_i = 1'b0;
    #1;
    tests_run++;
    if (rs2_addr_ao !== 5'd5) begin
      $display("[TB] FAIL reset_discards_held: rs2_ao=%0d expected 5", rs2_addr_ao);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_imm_sign_ext();
    test_stall_capture();
    test_squash_beats_stall();
    test_bubble();
    test_illegal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
